// File: rtl/rank_order_decoder_if.sv
// Handshake and data bundle between a rank-order list source and the decoder.
interface rank_order_decoder_if #(
    parameter int unsigned IMAGE_SIZE = 5,
    parameter int unsigned PIXEL_BITS = 4
);
    logic [PIXEL_BITS:0] sorted_indexes [IMAGE_SIZE];
    logic                new_list;
    logic [PIXEL_BITS:0] image          [IMAGE_SIZE];
    logic                done;
    logic                error;

    modport master (output sorted_indexes, output new_list,
                    input  image, input done, input error);
    modport slave  (input  sorted_indexes, input  new_list,
                    output image, output done, output error);
endinterface

// File: rtl/rank_order_decoder.sv
// Rebuilds an intensity image from a rank-ordered pixel index list, one rank per clock;
// the image and error flag are committed together when the whole list has been walked.
module rank_order_decoder #(
    parameter int unsigned IMAGE_SIZE      = 5,
    parameter int unsigned PIXEL_MAX_VALUE = 10,
    parameter int unsigned RANK_STEP       = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    rank_order_decoder_if.slave  bus
);
    localparam int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
    localparam int unsigned PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE);
    localparam int unsigned PW              = PIXEL_BITS + 1;
    localparam int unsigned RW              = IMAGE_SIZE_BITS;
    localparam int unsigned PROD_MAX        = (IMAGE_SIZE - 1) * RANK_STEP;
    localparam int unsigned VAL_MAX         = (PROD_MAX > PIXEL_MAX_VALUE) ? PROD_MAX : PIXEL_MAX_VALUE;
    localparam int unsigned VW              = $clog2(VAL_MAX + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DECODE, COMMIT} state_e;

    state_e                state_q, state_d;
    logic [RW-1:0]         rank_q, rank_d;
    logic [PW-1:0]         buf_q   [IMAGE_SIZE];
    logic [PW-1:0]         buf_d   [IMAGE_SIZE];
    logic [PW-1:0]         image_q [IMAGE_SIZE];
    logic [PW-1:0]         image_d [IMAGE_SIZE];
    logic [IMAGE_SIZE-1:0] mask_q, mask_d;
    logic                  err_acc_q, err_acc_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;

    logic [PW-1:0]         idx;
    logic [IMAGE_SIZE-1:0] hit;
    logic [VW-1:0]         prod;
    logic [PW-1:0]         val;
    logic                  in_range;
    logic                  dup;

    // Current rank's index as a one-hot pixel select (all zero when out of range) and its intensity.
    always_comb begin
        idx = '0;
        hit = '0;
        for (int unsigned i = 0; i < IMAGE_SIZE; i++) begin
            if (rank_q == RW'(i)) idx = bus.sorted_indexes[i];
        end
        for (int unsigned i = 0; i < IMAGE_SIZE; i++) begin
            hit[i] = (32'(idx) == i);
        end
        in_range = |hit;
        dup      = |(hit & mask_q);
        prod     = VW'(rank_q) * VW'(RANK_STEP);
        val      = (prod >= VW'(PIXEL_MAX_VALUE)) ? '0 : PW'(VW'(PIXEL_MAX_VALUE) - prod);
    end

    always_comb begin
        state_d   = state_q;
        rank_d    = rank_q;
        buf_d     = buf_q;
        image_d   = image_q;
        mask_d    = mask_q;
        err_acc_d = err_acc_q;
        error_d   = error_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.new_list) state_d = CLEAR;
            end
            CLEAR: begin
                for (int unsigned i = 0; i < IMAGE_SIZE; i++) buf_d[i] = '0;
                mask_d    = '0;
                rank_d    = '0;
                err_acc_d = 1'b0;
                state_d   = DECODE;
            end
            DECODE: begin
                // First (brightest) writer of a pixel wins; bad or repeated indexes only flag.
                if (!in_range || dup) begin
                    err_acc_d = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < IMAGE_SIZE; i++) begin
                        if (hit[i]) buf_d[i] = val;
                    end
                    mask_d = mask_q | hit;
                end
                rank_d = rank_q + RW'(1);
                if (rank_q == RW'(IMAGE_SIZE - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                image_d = buf_q;
                error_d = err_acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            rank_q    <= '0;
            buf_q     <= '{default: '0};
            image_q   <= '{default: '0};
            mask_q    <= '0;
            err_acc_q <= 1'b0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rank_q    <= rank_d;
            buf_q     <= buf_d;
            image_q   <= image_d;
            mask_q    <= mask_d;
            err_acc_q <= err_acc_d;
            error_q   <= error_d;
            done_q    <= done_d;
        end
    end

    assign bus.image = image_q;
    assign bus.done  = done_q;
    assign bus.error = error_q;
endmodule
